// File: rtl/frame_sequencer_pkg.sv
// frame_seq_pkg: state encoding, mode codes and cfg_ctrl bit positions shared by frame_sequencer.
package frame_seq_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PENDING = 2'd2, DONE = 2'd3} state_e;
   localparam logic [1:0] MODE_HOLD     = 2'b00;
   localparam logic [1:0] MODE_LOOP     = 2'b01;
   localparam logic [1:0] MODE_PINGPONG = 2'b10;
   localparam logic [1:0] MODE_ONESHOT  = 2'b11;
   localparam int CTRL_EN          = 0;
   localparam int CTRL_MODE_LSB    = 1;
   localparam int CTRL_MIRROR_AUTO = 3;
   localparam int CTRL_MIRROR_BASE = 4;
endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: SPI config, charlie scan strobe and charlie frame controls around frame_sequencer.
interface frame_sequencer_if #(
   parameter int FRAME_W = 2,
   parameter int PRESC_W = 16,
   parameter int DWELL_W = 8
);
   logic [7:0]         cfg_ctrl;
   logic [FRAME_W-1:0] cfg_first;
   logic [FRAME_W-1:0] cfg_last;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [PRESC_W-1:0] cfg_prescale;
   logic               scan_wrap;
   logic [FRAME_W-1:0] frame_index;
   logic               is_mirror;
   logic               busy;
   logic               done;
   modport master (
      output cfg_ctrl, cfg_first, cfg_last, cfg_dwell, cfg_prescale, scan_wrap,
      input  frame_index, is_mirror, busy, done
   );
   modport slave (
      input  cfg_ctrl, cfg_first, cfg_last, cfg_dwell, cfg_prescale, scan_wrap,
      output frame_index, is_mirror, busy, done
   );
endinterface

// File: rtl/frame_sequencer_tick_prescaler.sv
// tick_prescaler: counts 0..terminal and pulses tick on the terminal count; freeze holds, clr zeroes.
module tick_prescaler #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         freeze_i,
   input  logic [W-1:0] terminal_i,
   output logic         tick_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign tick_o = !freeze_i && !clr_i && cnt_q == terminal_i;
   always_comb cnt_d = clr_i ? '0 : freeze_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: steps charlie frame_index/is_mirror through a frame range, committing only on scan_wrap.
// Define FRAME_SEQ_STATUS_EN to add the status[7:0] readback port with a sticky wrap_seen bit.
module frame_sequencer
   import frame_seq_pkg::*;
#(
   parameter int FRAME_W = 2,
   parameter int PRESC_W = 16,
   parameter int DWELL_W = 8
) (
   input  logic clk,
   input  logic rst,
`ifdef FRAME_SEQ_STATUS_EN
   output logic [7:0] status,
`endif
   frame_sequencer_if.slave bus
);
   state_e state_q, state_d;
   logic [FRAME_W-1:0] frame_q, frame_d, next_q, next_d, first, last, nf;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W:0]   dmax;
   logic [1:0]         mode;
   logic dir_q, dir_d, ndir_q, ndir_d, tog_q, tog_d, wrap_q, wrap_d, mirror_q;
   logic en, auto, in_range, ndir, nwrap, at_end, tick, clr, freeze, unused_rsvd;

   assign en          = bus.cfg_ctrl[CTRL_EN];
   assign mode        = bus.cfg_ctrl[CTRL_MODE_LSB +: 2];
   assign auto        = bus.cfg_ctrl[CTRL_MIRROR_AUTO];
   assign unused_rsvd = ^bus.cfg_ctrl[7:5];
   assign first       = bus.cfg_first;
   assign last        = (bus.cfg_first > bus.cfg_last) ? bus.cfg_first : bus.cfg_last;
   assign in_range    = frame_q >= first && frame_q <= last;
   assign dmax        = (bus.cfg_dwell == '0) ? (DWELL_W+1)'(1) : {1'b0, bus.cfg_dwell};

   tick_prescaler #(.W(PRESC_W)) u_presc (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .freeze_i   (freeze),
      .terminal_i (bus.cfg_prescale),
      .tick_o     (tick)
   );

   // Candidate successor frame; out-of-range frames restart at first going up.
   always_comb begin
      nf     = first;
      ndir   = 1'b0;
      nwrap  = 1'b0;
      at_end = 1'b0;
      if (in_range)
         case (mode)
            MODE_LOOP: begin
               nwrap = frame_q == last;
               nf    = nwrap ? first : frame_q + 1'b1;
            end
            MODE_PINGPONG: begin
               ndir = dir_q;
               if (first != last) begin
                  ndir  = dir_q ? frame_q != first : frame_q == last;
                  nf    = (dir_q ? frame_q == first : frame_q != last) ? frame_q + 1'b1 : frame_q - 1'b1;
                  nwrap = dir_q && frame_q != first && frame_q - 1'b1 == first;
               end
            end
            MODE_ONESHOT: begin
               at_end = frame_q == last;
               nf     = frame_q + 1'b1;
            end
            default: ;
         endcase
   end

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      dir_d   = dir_q;
      tog_d   = tog_q;
      dwell_d = dwell_q;
      next_d  = next_q;
      ndir_d  = ndir_q;
      wrap_d  = wrap_q;
      clr     = 1'b0;
      freeze  = 1'b0;
      if (!en) begin
         state_d = IDLE;
         frame_d = first;
         dir_d   = 1'b0;
         tog_d   = 1'b0;
         dwell_d = '0;
         clr     = 1'b1;
      end else
         case (state_q)
            IDLE: begin
               state_d = RUN;
               frame_d = first;
               clr     = 1'b1;
            end
            RUN:
               if (mode == MODE_HOLD)
                  dwell_d = '0;
               else if (tick) begin
                  if ({1'b0, dwell_q} + 1'b1 >= dmax) begin
                     dwell_d = '0;
                     state_d = at_end ? DONE : PENDING;
                     next_d  = nf;
                     ndir_d  = ndir;
                     wrap_d  = nwrap;
                  end else
                     dwell_d = dwell_q + 1'b1;
               end
            PENDING: begin
               freeze = 1'b1;
               if (bus.scan_wrap) begin
                  state_d = RUN;
                  frame_d = next_q;
                  dir_d   = ndir_q;
                  tog_d   = tog_q ^ (wrap_q & auto);
               end
            end
            default: clr = 1'b1;
         endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         frame_q  <= '0;
         next_q   <= '0;
         dwell_q  <= '0;
         dir_q    <= 1'b0;
         ndir_q   <= 1'b0;
         tog_q    <= 1'b0;
         wrap_q   <= 1'b0;
         mirror_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         next_q   <= next_d;
         dwell_q  <= dwell_d;
         dir_q    <= dir_d;
         ndir_q   <= ndir_d;
         tog_q    <= tog_d;
         wrap_q   <= wrap_d;
         mirror_q <= bus.cfg_ctrl[CTRL_MIRROR_BASE] ^ tog_q;
      end
   end

   assign bus.frame_index = frame_q;
   assign bus.is_mirror   = mirror_q;
   assign bus.busy        = state_q == RUN || state_q == PENDING;
   assign bus.done        = state_q == DONE;

`ifdef FRAME_SEQ_STATUS_EN
   logic en_q, seen_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q   <= 1'b0;
         seen_q <= 1'b0;
      end else begin
         en_q   <= en;
         seen_q <= (en_q && !en) ? 1'b0 : seen_q | (state_q == PENDING && en && bus.scan_wrap && wrap_q);
      end
   end
   assign status = {state_q, dir_q, tog_q, 1'b0, seen_q, frame_q[1:0]};
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed stimulus with a scoreboard queue checked by an independent output monitor.
module tb_frame_sequencer;
   typedef struct {
      logic [1:0]  frame;
      logic        done;
      logic        mirror;
      int unsigned min_cyc;
   } exp_t;

   logic clk, rst;
   frame_sequencer_if #(.FRAME_W(2), .PRESC_W(16), .DWELL_W(8)) bus ();
`ifdef FRAME_SEQ_STATUS_EN
   logic [7:0] status;
`endif

   frame_sequencer #(.FRAME_W(2), .PRESC_W(16), .DWELL_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
`ifdef FRAME_SEQ_STATUS_EN
      .status (status),
`endif
      .bus    (bus)
   );

   exp_t        sb[$];
   int          n_chk = 0, n_err = 0;
   int unsigned pcyc = 0, last_sw = 0, run_k = 0;
   int          sdiv = 0;
   logic        scan_auto = 1'b0, scan_man = 1'b0, mon_busy = 1'b0;
   logic [1:0]  pf = '0;
   logic        pd = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] f, input logic d, input logic m, input int unsigned mc);
      exp_t e;
      e.frame = f;
      e.done = d;
      e.mirror = m;
      e.min_cyc = mc;
      sb.push_back(e);
   endtask

   task automatic cyc();
      @(negedge clk);
      sdiv = (sdiv + 1) % 64;
      bus.scan_wrap = scan_auto ? (sdiv == 0) : scan_man;
   endtask

   task automatic scan_pulse(input int gap);
      repeat (gap) cyc();
      scan_man = 1'b1;
      cyc();
      scan_man = 1'b0;
   endtask

   task automatic cfg(input logic [7:0] c, input logic [1:0] f, input logic [1:0] l,
                      input logic [7:0] d, input logic [15:0] p);
      bus.cfg_ctrl = c;
      bus.cfg_first = f;
      bus.cfg_last = l;
      bus.cfg_dwell = d;
      bus.cfg_prescale = p;
   endtask

   task automatic drain(input string nm, input int budget);
      int n = 0;
      while ((sb.size() != 0 || mon_busy) && n < budget) begin
         cyc();
         n++;
      end
      check(nm, sb.size(), 0);
   endtask

   initial forever begin
      @(posedge clk);
      pcyc++;
      if (bus.scan_wrap) last_sw = pcyc;
   end

   // Monitor: an output event is a frame change while busy, or done rising.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst && ((bus.frame_index != pf && bus.busy) || (bus.done && !pd))) begin
         mon_busy = 1'b1;
         check("event_expected", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("frame", bus.frame_index, e.frame);
            check("done", bus.done, e.done);
            check("busy", bus.busy, !e.done);
            if (!e.done) check("on_scan_wrap", int'(last_sw == pcyc), 1);
            if (e.min_cyc != 0) check("min_latency", int'(pcyc >= e.min_cyc), 1);
            pf = bus.frame_index;
            pd = bus.done;
            @(negedge clk);
            check("is_mirror", bus.is_mirror, e.mirror);
         end
         mon_busy = 1'b0;
      end
      pf = bus.frame_index;
      pd = bus.done;
   end

   initial begin
      bus.scan_wrap = 1'b0;
      rst = 1'b1;
      cfg(8'h13, 2'd2, 2'd3, 8'd2, 16'd3);
      repeat (3) cyc();
      check("rst_frame", bus.frame_index, 0);
      check("rst_mirror", bus.is_mirror, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      rst = 1'b0;
      bus.cfg_ctrl = 8'h00;
      repeat (2) cyc();

      // LOOP 0..3
      scan_auto = 1'b1;
      cfg(8'h02, 2'd0, 2'd3, 8'd2, 16'd3);
      repeat (3) cyc();
      check("loop_idle_frame", bus.frame_index, 0);
      run_k = pcyc + 1;
      push(2'd1, 1'b0, 1'b0, run_k + 8);
      push(2'd2, 1'b0, 1'b0, 0);
      push(2'd3, 1'b0, 1'b0, 0);
      push(2'd0, 1'b0, 1'b0, 0);
      bus.cfg_ctrl = 8'h03;
      drain("loop_drain", 1000);
      bus.cfg_ctrl = 8'h02;
      repeat (3) cyc();
      check("loop_stop_busy", bus.busy, 0);

      // PINGPONG 1..3 with mirror_auto
      cfg(8'h0C, 2'd1, 2'd3, 8'd2, 16'd3);
      repeat (3) cyc();
      check("pp_idle_frame", bus.frame_index, 1);
      check("pp_idle_mirror", bus.is_mirror, 0);
      push(2'd2, 1'b0, 1'b0, 0);
      push(2'd3, 1'b0, 1'b0, 0);
      push(2'd2, 1'b0, 1'b0, 0);
      push(2'd1, 1'b0, 1'b1, 0);
      push(2'd2, 1'b0, 1'b1, 0);
      bus.cfg_ctrl = 8'h0D;
      drain("pp_drain", 1500);
      bus.cfg_ctrl = 8'h0C;
      repeat (3) cyc();
      check("pp_stop_mirror", bus.is_mirror, 0);

      // ONESHOT 0..2
      cfg(8'h06, 2'd0, 2'd2, 8'd1, 16'd1);
      repeat (3) cyc();
      check("os_idle_frame", bus.frame_index, 0);
      push(2'd1, 1'b0, 1'b0, 0);
      push(2'd2, 1'b0, 1'b0, 0);
      push(2'd2, 1'b1, 1'b0, 0);
      bus.cfg_ctrl = 8'h07;
      drain("os_drain", 1000);
      repeat (100) cyc();
      check("os_hold_frame", bus.frame_index, 2);
      check("os_hold_done", bus.done, 1);
      check("os_hold_busy", bus.busy, 0);
      bus.cfg_ctrl = 8'h06;
      repeat (2) cyc();
      check("os_exit_frame", bus.frame_index, 0);
      check("os_exit_done", bus.done, 0);

      // dwell=0 acts as 1: scan at K+3 too early, commit on scan at K+5
      scan_auto = 1'b0;
      cyc();
      cfg(8'h02, 2'd0, 2'd1, 8'd0, 16'd3);
      repeat (3) cyc();
      run_k = pcyc + 1;
      push(2'd1, 1'b0, 1'b0, run_k + 5);
      bus.cfg_ctrl = 8'h03;
      scan_pulse(2);
      scan_pulse(1);
      cyc();
      drain("dwell0_drain", 50);
      bus.cfg_ctrl = 8'h02;
      repeat (3) cyc();

      // scan_wrap in the expiry cycle (K+4) is ignored; commit on K+10
      cfg(8'h02, 2'd0, 2'd1, 8'd1, 16'd3);
      repeat (3) cyc();
      run_k = pcyc + 1;
      push(2'd1, 1'b0, 1'b0, run_k + 10);
      bus.cfg_ctrl = 8'h03;
      scan_pulse(3);
      scan_pulse(5);
      cyc();
      drain("expiry_drain", 50);
      bus.cfg_ctrl = 8'h02;
      repeat (3) cyc();

      // first > last: range collapses to first
      scan_auto = 1'b1;
      cfg(8'h02, 2'd3, 2'd1, 8'd1, 16'd0);
      repeat (3) cyc();
      check("range_idle_frame", bus.frame_index, 3);
      bus.cfg_ctrl = 8'h03;
      repeat (200) cyc();
      check("range_frame", bus.frame_index, 3);
      check("range_busy", bus.busy, 1);
      bus.cfg_ctrl = 8'h02;
      repeat (3) cyc();

      // abort: enable drops on the same edge a scan_wrap arrives while PENDING
      scan_auto = 1'b0;
      cyc();
      cfg(8'h02, 2'd0, 2'd3, 8'd1, 16'd3);
      repeat (3) cyc();
      bus.cfg_ctrl = 8'h03;
      repeat (5) cyc();
      check("abort_pre_busy", bus.busy, 1);
      scan_man = 1'b1;
      cyc();
      scan_man = 1'b0;
      bus.cfg_ctrl = 8'h02;
      cyc();
      check("abort_frame", bus.frame_index, 0);
      check("abort_busy", bus.busy, 0);
      repeat (3) cyc();
      check("abort_frame_late", bus.frame_index, 0);

      // rst mid-RUN
      cfg(8'h10, 2'd2, 2'd3, 8'd1, 16'd0);
      repeat (3) cyc();
      bus.cfg_ctrl = 8'h11;
      repeat (10) cyc();
      check("hold_busy", bus.busy, 1);
      check("hold_frame", bus.frame_index, 2);
      check("hold_mirror", bus.is_mirror, 1);
      rst = 1'b1;
      cyc();
      check("rst_run_frame", bus.frame_index, 0);
      check("rst_run_mirror", bus.is_mirror, 0);
      check("rst_run_busy", bus.busy, 0);
      check("rst_run_done", bus.done, 0);
      rst = 1'b0;
      bus.cfg_ctrl = 8'h00;
      repeat (3) cyc();
      check("final_queue", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
